branch_resolve: RTL

//  Consumes the EX-stage branch comparator result for RV32I branches and checks it against the fetch-time prediction.
//  On mispredict, issues one flush pulse and a held valid/ready redirect to fetch.

---
 rtl/branch_resolve.sv | 136 +++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// Branch resolution for RV32I conditional branches: checks the EX outcome against
// the fetch-time prediction, raises a one-cycle flush and a held redirect on a
// mispredict, maintains the 2-bit predictor table and saturating perf counters.
module branch_resolve #(
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_cmp_out,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ready,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_t;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [31:0]        redir_pc_nx;
    logic               flush_nx;
    logic               legal;
    logic               accept;
    logic               taken;
    logic               mispredict;
    logic [IDX_W-1:0]   ex_idx;
    logic [IDX_W-1:0]   if_idx;
    logic [1:0]         bht_cur;
    logic [1:0]         bht_nx;
    logic [1:0]         bht [BHT_ENTRIES];
    logic               unused_bits;

    assign ex_idx        = ex_pc[IDX_W+1:2];
    assign if_idx        = if_pc[IDX_W+1:2];
    // Pre-update table read; a same-cycle write becomes visible next cycle
    assign if_pred_taken = bht[if_idx][1];
    assign redir_valid   = (state == REDIRECT);
    assign unused_bits   = ^{ex_cmp_out[31:1], if_pc[31:IDX_W+2], if_pc[1:0]};

    // Outcome decode and saturating predictor step for the EX branch
    always_comb begin
        legal      = ex_funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
        taken      = ex_cmp_out[0];
        mispredict = (taken != ex_pred_taken);
        bht_cur    = bht[ex_idx];
        bht_nx     = bht_cur;
        if (taken && (bht_cur != 2'b11)) begin
            bht_nx = bht_cur + 2'd1;
        end else if (!taken && (bht_cur != 2'b00)) begin
            bht_nx = bht_cur - 2'd1;
        end
    end

    // Next-state and registered-output next values
    always_comb begin
        state_nx    = state;
        redir_pc_nx = redir_pc;
        flush_nx    = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                accept = ex_valid && legal;
                if (accept && mispredict) begin
                    state_nx    = REDIRECT;
                    flush_nx    = 1'b1;
                    redir_pc_nx = taken ? ex_target : (ex_pc + 32'd4);
                end
            end
            REDIRECT: begin
                if (redir_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Redirect payload, flush pulse, perf counters and predictor table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_pc         <= '0;
            flush            <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else begin
            redir_pc <= redir_pc_nx;
            flush    <= flush_nx;
            if (accept) begin
                bht[ex_idx] <= bht_nx;
                if (branch_count != '1) begin
                    branch_count <= branch_count + CNT_W'(1);
                end
                if (mispredict && (mispredict_count != '1)) begin
                    mispredict_count <= mispredict_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
